// File: rtl/reg_file_pkg.sv
// Shared register-file widths and types for decode, register file and write-back.
package reg_file_pkg;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// One combinational read port: NUM_REGS:1 mux with optional R0 zero gating.
// Build option: REGFILE_ZERO_R0_EN forces reads of address 0 to zero.
module reg_file_read_port
   import reg_file_pkg::*;
(
   input  reg_data_t i_regs [NUM_REGS],
   input  reg_addr_t i_addr,
   output reg_data_t o_data
);

   always_comb begin
      o_data = i_regs[i_addr];
`ifdef REGFILE_ZERO_R0_EN
      if (i_addr == ADDR_W'(0)) begin
         o_data = '0;
      end
`endif
   end

endmodule : reg_file_read_port

// File: rtl/reg_file_8x16.sv
// 8 x 16-bit register file: two combinational read ports, one synchronous write port.
// Build option: REGFILE_ZERO_R0_EN makes register 0 hard-wired zero.
module reg_file_8x16
   import reg_file_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      RegWrite,
   input  reg_addr_t read_reg_1,
   input  reg_addr_t read_reg_2,
   input  reg_addr_t write_reg,
   input  reg_data_t write_data,
   output reg_data_t read_data_1,
   output reg_data_t read_data_2
);

   reg_data_t r_regs [NUM_REGS];
   logic      w_wr_en;

   // Writes to r0 are dropped when it is hard-wired zero.
`ifdef REGFILE_ZERO_R0_EN
   assign w_wr_en = RegWrite && (write_reg != ADDR_W'(0));
`else
   assign w_wr_en = RegWrite;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[write_reg] <= write_data;
      end
   end

   reg_file_read_port u_rd_port_1 (
      .i_regs (r_regs),
      .i_addr (read_reg_1),
      .o_data (read_data_1)
   );

   reg_file_read_port u_rd_port_2 (
      .i_regs (r_regs),
      .i_addr (read_reg_2),
      .o_data (read_data_2)
   );

endmodule : reg_file_8x16

// File: tb/tb_reg_file_8x16.sv
// Scoreboard bench for reg_file_8x16; expected read values come from a bench-side register model.
module tb_reg_file_8x16;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite;
   logic [2:0]  read_reg_1;
   logic [2:0]  read_reg_2;
   logic [2:0]  write_reg;
   logic [15:0] write_data;
   logic [15:0] read_data_1;
   logic [15:0] read_data_2;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [15:0] m_regs [8];
   logic [15:0] sb_q [$];

   reg_file_8x16 dut (
      .clk         (clk),
      .reset       (reset),
      .RegWrite    (RegWrite),
      .read_reg_1  (read_reg_1),
      .read_reg_2  (read_reg_2),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .read_data_1 (read_data_1),
      .read_data_2 (read_data_2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_rd(input logic [2:0] a);
`ifdef REGFILE_ZERO_R0_EN
      if (a == 3'd0) return 16'h0000;
`endif
      return m_regs[a];
   endfunction

   // Drive both read addresses, push expectations, then pop and compare.
   task automatic read_pair(input string tag, input logic [2:0] a1, input logic [2:0] a2);
      logic [15:0] e;
      read_reg_1 = a1;
      read_reg_2 = a2;
      sb_q.push_back(model_rd(a1));
      sb_q.push_back(model_rd(a2));
      #1;
      e = sb_q.pop_front();
      check({tag, "_rd1"}, read_data_1, e);
      e = sb_q.pop_front();
      check({tag, "_rd2"}, read_data_2, e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_write(input logic [2:0] a, input logic [15:0] d);
`ifdef REGFILE_ZERO_R0_EN
      if (a == 3'd0) return;
`endif
      m_regs[a] = d;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [15:0] d);
      RegWrite   = 1'b1;
      write_reg  = a;
      write_data = d;
      tick();
      model_write(a, d);
      RegWrite   = 1'b0;
   endtask

   initial begin
      reset      = 1'b0;
      RegWrite   = 1'b0;
      read_reg_1 = 3'd0;
      read_reg_2 = 3'd0;
      write_reg  = 3'd0;
      write_data = 16'h0000;
      for (int i = 0; i < 8; i++) m_regs[i] = 16'hxxxx;
      #2;

      // Reset, then every address on both ports reads zero
      reset = 1'b1;
      tick();
      model_reset();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) read_pair("reset", 3'(i), 3'(7 - i));

      // Write r4 = 20: old value before the edge, new after
      RegWrite   = 1'b1;
      write_reg  = 3'd4;
      write_data = 16'd20;
      read_pair("wr4_pre", 3'd4, 3'd0);
      tick();
      model_write(3'd4, 16'd20);
      RegWrite = 1'b0;
      read_pair("wr4_post", 3'd4, 3'd0);

      // RegWrite low holds contents
      write_data = 16'd99;
      for (int i = 0; i < 4; i++) begin
         tick();
         read_pair("hold", 3'd4, 3'd4);
      end

      // Boundary data patterns, same register on both ports
      do_write(3'd7, 16'hFFFF);
      do_write(3'd3, 16'h8001);
      read_pair("r7_r3", 3'd7, 3'd3);
      read_pair("r3_r3", 3'd3, 3'd3);

      // Reset beats a simultaneous write
      do_write(3'd5, 16'h5555);
      read_pair("r5_set", 3'd5, 3'd7);
      reset      = 1'b1;
      RegWrite   = 1'b1;
      write_reg  = 3'd5;
      write_data = 16'd7;
      tick();
      model_reset();
      reset    = 1'b0;
      RegWrite = 1'b0;
      read_pair("rst_prio", 3'd5, 3'd7);

      // r0 write: ordinary or hard-wired zero depending on build
      do_write(3'd0, 16'h1234);
      read_pair("r0", 3'd0, 3'd0);

      // Random traffic, reads also aimed at the register being written
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  a;
         logic [15:0] d;
         a = 3'($urandom_range(0, 7));
         d = 16'($urandom);
         RegWrite   = 1'($urandom_range(0, 1));
         write_reg  = a;
         write_data = d;
         read_pair("rnd_pre", a, 3'($urandom_range(0, 7)));
         tick();
         if (RegWrite) model_write(a, d);
         RegWrite = 1'b0;
         read_pair("rnd_post", a, 3'($urandom_range(0, 7)));
      end

      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_reg_file_8x16
